// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one 8-lane int16 MAC. Issues N groups of K atoms,
// accumulates the fixed-latency MAC results of each group into a wide sum and
// hands the sums out through a small credit-protected result FIFO.
module mac_seq_ctrl #(
  parameter int unsigned MAC_LAT   = 3,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_atoms,
  input  logic [CNT_W-1:0] cmd_outs,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             mac_pvld,
  input  logic             mac_out_pvld,
  input  logic [35:0]      mac_out_data,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BlkW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int unsigned CrdW = $clog2(RES_DEPTH + 1);
  localparam int unsigned PtrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [BlkW-1:0]  BlkLast = BlkW'(MAC_LAT - 1);
  localparam logic [CrdW-1:0]  CrdMax  = CrdW'(RES_DEPTH);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(RES_DEPTH - 1);

  typedef enum logic [1:0] {StBlank, StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [BlkW-1:0]  blank_cnt_q, blank_cnt_d;
  logic [CNT_W-1:0] k_q, k_d, n_q, n_d;
  logic [CNT_W-1:0] issue_atom_q, issue_atom_d, issue_out_q, issue_out_d;
  logic [CNT_W-1:0] ret_atom_q, ret_atom_d, ret_out_q, ret_out_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CrdW-1:0]  credit_q, credit_d;
  logic             done_q, done_d;

  logic [ACC_W-1:0] mem_q [RES_DEPTH];
  logic [ACC_W-1:0] mem_d [RES_DEPTH];
  logic             last_q [RES_DEPTH];
  logic             last_d [RES_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CrdW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic             cmd_fire, cmd_zero;
  logic             issue_grp_end, issue_last, consume;
  logic             ret_en, push, pop, drain_done;
  logic signed [35:0] mac_out_s;
  logic [ACC_W-1:0] sext, acc_sum;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign cmd_fire      = cmd_valid & cmd_ready;
  assign cmd_zero      = (cmd_atoms == '0) | (cmd_outs == '0);
  assign issue_grp_end = mac_pvld & (issue_atom_q == k_q - CntOne);
  assign issue_last    = (issue_out_q == n_q - CntOne);
  assign consume       = mac_pvld & (issue_atom_q == '0);
  // Returns are only counted while a command is live and not yet fully returned.
  assign ret_en        = mac_out_pvld & ((state_q == StRun) | (state_q == StDrain)) &
                         (ret_out_q != n_q);
  assign push          = ret_en & (ret_atom_q == k_q - CntOne);
  assign pop           = acc_valid & acc_ready;
  assign drain_done    = (ret_out_q == n_q) & (fifo_cnt_q == '0);

  assign mac_out_s = mac_out_data;
  assign sext      = ACC_W'(mac_out_s);
  assign acc_sum   = (ret_atom_q == '0) ? sext : acc_q + sext;

  assign src_ready = mac_pvld;
  assign done      = done_q;
  assign acc_valid = (fifo_cnt_q != '0);
  assign acc_data  = mem_q[rd_ptr_q];
  assign acc_last  = last_q[rd_ptr_q];

  // FSM state register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state_q <= StBlank;
    else                state_q <= state_d;
  end

  // FSM next state; BLANK counts out the MAC pipeline after reset.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      StBlank: begin
        if (blank_cnt_q == BlkLast) state_d = StIdle;
        else                        blank_cnt_d = blank_cnt_q + 1'b1;
      end
      StIdle:  if (cmd_fire && !cmd_zero) state_d = StRun;
      StRun:   if (issue_grp_end && issue_last) state_d = StDrain;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StBlank;
    endcase
  end

  // FSM outputs; a new group only starts when a result slot is reserved.
  always_comb begin
    cmd_ready = 1'b0;
    mac_pvld  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      StIdle:  cmd_ready = 1'b1;
      StRun: begin
        busy     = 1'b1;
        mac_pvld = src_valid & ((issue_atom_q != '0) | (credit_q != '0));
      end
      StDrain: busy = 1'b1;
      default: ;
    endcase
  end

  // Command latch, issue/return counters, accumulator, credits and done pulse.
  always_comb begin
    k_d          = k_q;
    n_d          = n_q;
    issue_atom_d = issue_atom_q;
    issue_out_d  = issue_out_q;
    ret_atom_d   = ret_atom_q;
    ret_out_d    = ret_out_q;
    acc_d        = acc_q;
    credit_d     = credit_q;
    done_d       = 1'b0;
    if (cmd_fire) begin
      k_d          = cmd_atoms;
      n_d          = cmd_outs;
      issue_atom_d = '0;
      issue_out_d  = '0;
      ret_atom_d   = '0;
      ret_out_d    = '0;
      done_d       = cmd_zero;
    end
    if (mac_pvld) begin
      if (issue_grp_end) begin
        issue_atom_d = '0;
        issue_out_d  = issue_out_q + CntOne;
      end else begin
        issue_atom_d = issue_atom_q + CntOne;
      end
    end
    if (ret_en) begin
      acc_d = acc_sum;
      if (push) begin
        ret_atom_d = '0;
        ret_out_d  = ret_out_q + CntOne;
      end else begin
        ret_atom_d = ret_atom_q + CntOne;
      end
    end
    case ({consume, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = (credit_q == CrdMax) ? credit_q : credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
    if ((state_q == StDrain) && drain_done) done_d = 1'b1;
  end

  // Result FIFO next state (fall-through: head is always on acc_data).
  always_comb begin
    mem_d      = mem_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q]  = acc_sum;
      last_d[wr_ptr_q] = (ret_out_q == n_q - CntOne);
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Datapath and FIFO registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      blank_cnt_q  <= '0;
      k_q          <= '0;
      n_q          <= '0;
      issue_atom_q <= '0;
      issue_out_q  <= '0;
      ret_atom_q   <= '0;
      ret_out_q    <= '0;
      acc_q        <= '0;
      credit_q     <= CrdMax;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      blank_cnt_q  <= blank_cnt_d;
      k_q          <= k_d;
      n_q          <= n_d;
      issue_atom_q <= issue_atom_d;
      issue_out_q  <= issue_out_d;
      ret_atom_q   <= ret_atom_d;
      ret_out_q    <= ret_out_d;
      acc_q        <= acc_d;
      credit_q     <= credit_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      mem_q        <= mem_d;
      last_q       <= last_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a 3-deep MAC model answers each issue, a scoreboard
// queue holds the expected group sums and a negedge monitor compares them.
module tb_mac_seq_ctrl;

  localparam int unsigned MacLat   = 3;
  localparam int unsigned AccW     = 48;
  localparam int unsigned CntW     = 12;
  localparam int unsigned ResDepth = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [CntW-1:0] cmd_atoms = '0;
  logic [CntW-1:0] cmd_outs = '0;
  logic            src_valid = 1'b0;
  logic            src_ready;
  logic            mac_pvld;
  logic            mac_out_pvld;
  logic [35:0]     mac_out_data;
  logic            acc_valid;
  logic            acc_ready = 1'b0;
  logic [AccW-1:0] acc_data;
  logic            acc_last;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .MAC_LAT  (MacLat),
    .ACC_W    (AccW),
    .CNT_W    (CntW),
    .RES_DEPTH(ResDepth)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_atoms     (cmd_atoms),
    .cmd_outs      (cmd_outs),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .mac_pvld      (mac_pvld),
    .mac_out_pvld  (mac_out_pvld),
    .mac_out_data  (mac_out_data),
    .acc_valid     (acc_valid),
    .acc_ready     (acc_ready),
    .acc_data      (acc_data),
    .acc_last      (acc_last),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic [AccW-1:0] data;
    logic            last;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [35:0] ret_vals[$];

  int errors = 0;
  int checks = 0;
  int pv_cnt = 0;
  int done_cnt = 0;
  int bad_issue = 0;
  int cyc = 0;
  int pv_first = -1;
  int pv_last = -1;

  // MAC model: unreset pipeline, returns the next queued value MacLat cycles after issue.
  logic        force_mode = 1'b1;
  logic        force_pvld = 1'b0;
  logic [35:0] force_data = '0;
  logic        pv1 = 1'b0, pv2 = 1'b0, pv3 = 1'b0;
  logic [35:0] pd1 = '0, pd2 = '0, pd3 = '0;
  logic [35:0] nv;

  assign mac_out_pvld = force_mode ? force_pvld : pv3;
  assign mac_out_data = force_mode ? force_data : pd3;

  always @(posedge clk) begin
    nv = '0;
    if (mac_pvld && ret_vals.size() > 0) nv = ret_vals.pop_front();
    pv1 <= mac_pvld;
    pd1 <= nv;
    pv2 <= pv1;
    pd2 <= pd1;
    pv3 <= pv2;
    pd3 <= pd2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: issue/done bookkeeping and scoreboard comparison on each handshake.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mac_pvld) begin
        pv_cnt++;
        if (!src_valid) bad_issue++;
        if (pv_first < 0) pv_first = cyc;
        pv_last = cyc;
      end
      if (done) done_cnt++;
      if (acc_valid && acc_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL acc_unexpected: actual=%0h required=none", acc_data);
        end else begin
          mon_e = expq.pop_front();
          chk("acc_data", 64'(acc_data), 64'(mon_e.data));
          chk("acc_last", 64'(acc_last), 64'(mon_e.last));
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic send_cmd(input int k, input int n);
    cmd_atoms = CntW'(k);
    cmd_outs  = CntW'(n);
    cmd_valid = 1'b1;
    smp();
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    nxt();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    for (int i = 0; i < 200 && done_cnt == base; i++) nxt();
    chk({name, "_done"}, 64'(done_cnt - base), 64'd1);
  endtask

  int pv0, d0, b0;

  initial begin
    // Post-reset blanking with a zero command waiting and a forced MAC return.
    force_mode = 1'b1;
    force_pvld = 1'b1;
    force_data = 36'h0_0000_1234;
    cmd_valid  = 1'b1;
    cmd_atoms  = '0;
    cmd_outs   = CntW'(5);
    #1;
    chk("reset_outputs", 64'({cmd_ready, src_ready, mac_pvld, acc_valid, acc_last, busy, done}),
        64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("blank_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("blank_acc_valid", 64'(acc_valid), 64'd0);
      nxt();
    end
    smp();
    chk("post_blank_cmd_ready", 64'(cmd_ready), 64'd1);
    nxt();
    cmd_valid  = 1'b0;
    force_pvld = 1'b0;
    force_mode = 1'b0;

    // Zero command: done the cycle after accept, nothing else moves.
    smp();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      smp();
      chk("zero_quiet", 64'({done, busy, mac_pvld, acc_valid}), 64'd0);
    end
    nxt();

    // Basic accumulation K=3 N=2.
    src_valid = 1'b1;
    acc_ready = 1'b1;
    ret_vals.push_back(36'd100);
    ret_vals.push_back(36'hF_FFFF_FFFB);
    ret_vals.push_back(36'd7);
    ret_vals.push_back(36'd1);
    ret_vals.push_back(36'd2);
    ret_vals.push_back(36'd3);
    expq.push_back('{data: 48'd102, last: 1'b0});
    expq.push_back('{data: 48'd6, last: 1'b1});
    pv0 = pv_cnt;
    d0 = done_cnt;
    pv_first = -1;
    send_cmd(3, 2);
    wait_done(d0, "basic");
    chk("basic_issues", 64'(pv_cnt - pv0), 64'd6);
    chk("basic_span", 64'(pv_last - pv_first + 1), 64'd6);
    repeat (4) nxt();
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
    chk("basic_q_empty", 64'(expq.size()), 64'd0);

    // Sign extension: two most-negative 36-bit returns.
    ret_vals.push_back(36'h8_0000_0000);
    ret_vals.push_back(36'h8_0000_0000);
    expq.push_back('{data: 48'hFFF0_0000_0000, last: 1'b1});
    d0 = done_cnt;
    send_cmd(2, 1);
    wait_done(d0, "sign");

    // Credit backpressure K=1 N=4.
    acc_ready = 1'b0;
    ret_vals.push_back(36'd10);
    ret_vals.push_back(36'd20);
    ret_vals.push_back(36'd30);
    ret_vals.push_back(36'd40);
    expq.push_back('{data: 48'd10, last: 1'b0});
    expq.push_back('{data: 48'd20, last: 1'b0});
    expq.push_back('{data: 48'd30, last: 1'b0});
    expq.push_back('{data: 48'd40, last: 1'b1});
    pv0 = pv_cnt;
    d0 = done_cnt;
    send_cmd(1, 4);
    repeat (12) nxt();
    chk("credit_two_issues", 64'(pv_cnt - pv0), 64'd2);
    chk("credit_stall_valid", 64'(acc_valid), 64'd1);
    chk("credit_hold_data", 64'(acc_data), 64'd10);
    acc_ready = 1'b1;
    nxt();
    acc_ready = 1'b0;
    repeat (12) nxt();
    chk("credit_one_more", 64'(pv_cnt - pv0), 64'd3);
    chk("credit_hold_data2", 64'(acc_data), 64'd20);
    acc_ready = 1'b1;
    wait_done(d0, "credit");
    chk("credit_total", 64'(pv_cnt - pv0), 64'd4);

    // Source gaps K=4 with src_valid toggling.
    src_valid = 1'b0;
    ret_vals.push_back(36'd11);
    ret_vals.push_back(36'd22);
    ret_vals.push_back(36'hF_FFFF_FFDF);
    ret_vals.push_back(36'd44);
    expq.push_back('{data: 48'd44, last: 1'b1});
    pv0 = pv_cnt;
    d0 = done_cnt;
    b0 = bad_issue;
    send_cmd(4, 1);
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      src_valid = ~src_valid;
      nxt();
    end
    chk("gap_done", 64'(done_cnt - d0), 64'd1);
    chk("gap_issues", 64'(pv_cnt - pv0), 64'd4);
    chk("gap_only_on_valid", 64'(bad_issue - b0), 64'd0);

    // Mid-run reset: stale returns must be swallowed by the blanking window.
    src_valid = 1'b1;
    ret_vals.push_back(36'd7);
    ret_vals.push_back(36'd7);
    ret_vals.push_back(36'd7);
    ret_vals.push_back(36'd7);
    send_cmd(4, 1);
    nxt();
    nxt();
    rst = 1'b1;
    #1;
    chk("midrst_outputs",
        64'({cmd_ready, src_ready, mac_pvld, acc_valid, acc_last, busy, done}), 64'd0);
    chk("midrst_acc_data", 64'(acc_data), 64'd0);
    nxt();
    rst = 1'b0;
    ret_vals.delete();
    for (int i = 0; i < 20 && !cmd_ready; i++) nxt();
    ret_vals.push_back(36'd5);
    ret_vals.push_back(36'd6);
    expq.push_back('{data: 48'd11, last: 1'b1});
    d0 = done_cnt;
    send_cmd(2, 1);
    wait_done(d0, "after_rst");

    repeat (3) nxt();
    chk("final_q_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
